// File: rtl/edge_detector_multi_if.sv
// Signal bundle for the multi-channel edge detector.
// There is no valid/ready handshake: in_i, mode_i and clr_i are sampled on
// every rising clk edge, and every output is a registered level or pulse
// (any_pending_o is the one combinational output, an OR of pending_o).
interface edge_detector_multi_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   in_i;
    logic [2*WIDTH-1:0] mode_i;
    logic [WIDTH-1:0]   clr_i;
    logic [WIDTH-1:0]   level_o;
    logic [WIDTH-1:0]   edge_o;
    logic [WIDTH-1:0]   dir_o;
    logic [WIDTH-1:0]   pending_o;
    logic [WIDTH-1:0]   overflow_o;
    logic               any_pending_o;

    // Stimulus side: drives inputs, observes results.
    modport master (
        output in_i, mode_i, clr_i,
        input  level_o, edge_o, dir_o, pending_o, overflow_o, any_pending_o
    );

    // Detector side.
    modport slave (
        input  in_i, mode_i, clr_i,
        output level_o, edge_o, dir_o, pending_o, overflow_o, any_pending_o
    );
endinterface

// File: rtl/edge_detector_multi.sv
// Multi-channel debounced edge detector.
// Per channel: optional synchroniser -> stability filter -> accepted level.
// A qualifying accepted transition is flagged for one cycle (qual_q), then
// presented as a one-cycle edge_o pulse with sticky pending/overflow flags.
module edge_detector_multi #(
    parameter int   WIDTH         = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 3,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    edge_detector_multi_if.slave bus
);

    localparam int CW = $clog2(FILTER_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0]         s;
    logic [WIDTH-1:0]         acc_q, acc_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         qual_q, qual_d;
    logic [WIDTH-1:0]         rise_q, rise_d;
    logic [WIDTH-1:0]         edge_q;
    logic [WIDTH-1:0]         dir_q;
    logic [WIDTH-1:0]         pending_q;
    logic [WIDTH-1:0]         overflow_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = bus.in_i;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];

            // Shift raw inputs through the synchroniser chain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= {WIDTH{RESET_LEVEL}};
                    end
                end else begin
                    sync_q[0] <= bus.in_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Filter: count consecutive cycles where s differs from acc; accept on the
    // FILTER_CYCLES-th one. Mode is sampled here, in the accepting cycle.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        qual_d = '0;
        rise_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == acc_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                acc_d[i]  = s[i];
                cnt_d[i]  = '0;
                rise_d[i] = s[i];
                qual_d[i] = s[i] ? bus.mode_i[2*i] : bus.mode_i[2*i+1];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Filter state and the one-cycle qualified-transition flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= {WIDTH{RESET_LEVEL}};
            cnt_q  <= '0;
            qual_q <= '0;
            rise_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            qual_q <= qual_d;
            rise_q <= rise_d;
        end
    end

    // Event outputs: pulse, direction and sticky flags. A coincident clear
    // loses to a new event for pending but wins for overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q     <= '0;
            dir_q      <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            edge_q     <= qual_q;
            dir_q      <= qual_q & rise_q;
            pending_q  <= qual_q | (pending_q & ~bus.clr_i);
            overflow_q <= ~bus.clr_i & (overflow_q | (qual_q & pending_q));
        end
    end

    assign bus.level_o       = acc_q;
    assign bus.edge_o        = edge_q;
    assign bus.dir_o         = dir_q;
    assign bus.pending_o     = pending_q;
    assign bus.overflow_o    = overflow_q;
    assign bus.any_pending_o = |pending_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi: a default-parameter instance (a)
// and a RESET_LEVEL=1 instance (b) sharing one clock.
module tb_edge_detector_multi;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   vectors;
    int   miscompares;
    logic [3:0] edge_or;

    edge_detector_multi_if #(.WIDTH(4)) bus_a ();
    edge_detector_multi_if #(.WIDTH(4)) bus_b ();

    edge_detector_multi #(
        .WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_LEVEL(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_a), .bus(bus_a)
    );

    edge_detector_multi #(
        .WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_LEVEL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(bus_b)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick n times, OR-ing edge_o of instance a into edge_or.
    task automatic run_a(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            edge_or = edge_or | bus_a.edge_o;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        edge_or     = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.in_i = 4'b0000; bus_a.mode_i = 8'h00; bus_a.clr_i = 4'b0000;
        bus_b.in_i = 4'b1111; bus_b.mode_i = 8'hFF; bus_b.clr_i = 4'b0000;
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        // Reset state.
        chk("rst_a_level", bus_a.level_o, 4'b0000);
        chk("rst_a_edge", bus_a.edge_o, 4'b0000);
        chk("rst_a_pending", bus_a.pending_o, 4'b0000);
        chk("rst_a_any", bus_a.any_pending_o, 1'b0);
        chk("rst_b_level", bus_b.level_o, 4'b1111);
        tick();
        tick();
        chk("rst_b_level_held", bus_b.level_o, 4'b1111);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Rise on ch0, mode 01: pulse 6 edges after the change.
        bus_a.mode_i = 8'b00_00_00_01;
        bus_a.in_i   = 4'b0001;
        run_a(4);
        chk("rise_lvl_e4", bus_a.level_o, 4'b0000);
        run_a(1);
        chk("rise_lvl_e5", bus_a.level_o, 4'b0001);
        chk("rise_noedge_e5", edge_or, 4'b0000);
        tick();
        chk("rise_edge_e6", bus_a.edge_o, 4'b0001);
        chk("rise_dir_e6", bus_a.dir_o, 4'b0001);
        chk("rise_pend_e6", bus_a.pending_o, 4'b0001);
        chk("rise_any_e6", bus_a.any_pending_o, 1'b1);
        tick();
        chk("rise_edge_e7", bus_a.edge_o, 4'b0000);
        chk("rise_dir_e7", bus_a.dir_o, 4'b0000);
        chk("rise_pend_e7", bus_a.pending_o, 4'b0001);
        bus_a.clr_i = 4'b0001;
        tick();
        bus_a.clr_i = 4'b0000;
        chk("clr_pend", bus_a.pending_o, 4'b0000);
        chk("clr_any", bus_a.any_pending_o, 1'b0);

        // Glitches on ch1 of two synced cycles, one-cycle gap: rejected.
        bus_a.mode_i = 8'b00_00_11_01;
        edge_or = '0;
        bus_a.in_i = 4'b0011; run_a(2);
        bus_a.in_i = 4'b0001; run_a(1);
        bus_a.in_i = 4'b0011; run_a(2);
        bus_a.in_i = 4'b0001; run_a(8);
        chk("glitch_level", bus_a.level_o, 4'b0001);
        chk("glitch_edge", edge_or, 4'b0000);
        chk("glitch_pend", bus_a.pending_o, 4'b0000);

        // ch2 mode 10: rise silent, fall pulses with dir 0.
        bus_a.mode_i = 8'b00_10_00_01;
        edge_or = '0;
        bus_a.in_i = 4'b0101; run_a(8);
        chk("m10_rise_level", bus_a.level_o, 4'b0101);
        chk("m10_rise_edge", edge_or, 4'b0000);
        chk("m10_rise_pend", bus_a.pending_o, 4'b0000);
        bus_a.in_i = 4'b0001; run_a(5);
        chk("m10_fall_level", bus_a.level_o, 4'b0001);
        chk("m10_fall_noedge", edge_or, 4'b0000);
        tick();
        chk("m10_fall_edge", bus_a.edge_o, 4'b0100);
        chk("m10_fall_dir", bus_a.dir_o, 4'b0000);
        chk("m10_fall_pend", bus_a.pending_o, 4'b0100);
        bus_a.clr_i = 4'b1111;
        tick();
        bus_a.clr_i = 4'b0000;
        chk("m10_clr", bus_a.pending_o, 4'b0000);

        // ch3 mode 00: level tracks, nothing else.
        edge_or = '0;
        bus_a.in_i = 4'b1001; run_a(8);
        chk("m00_level", bus_a.level_o, 4'b1001);
        chk("m00_edge", edge_or, 4'b0000);
        chk("m00_pend", bus_a.pending_o, 4'b0000);
        chk("m00_ovf", bus_a.overflow_o, 4'b0000);

        // ch0 mode 11: three events; overflow on the second, then a clear
        // coinciding with the third.
        bus_a.mode_i = 8'b00_10_00_11;
        bus_a.in_i = 4'b1000; run_a(6);
        chk("ev1_edge", bus_a.edge_o, 4'b0001);
        chk("ev1_dir", bus_a.dir_o, 4'b0000);
        chk("ev1_ovf", bus_a.overflow_o, 4'b0000);
        run_a(2);
        bus_a.in_i = 4'b1001; run_a(6);
        chk("ev2_edge", bus_a.edge_o, 4'b0001);
        chk("ev2_dir", bus_a.dir_o, 4'b0001);
        chk("ev2_pend", bus_a.pending_o, 4'b0001);
        chk("ev2_ovf", bus_a.overflow_o, 4'b0001);
        run_a(2);
        bus_a.in_i = 4'b1000; run_a(5);
        chk("ev3_ovf_before", bus_a.overflow_o, 4'b0001);
        bus_a.clr_i = 4'b0001;
        tick();
        bus_a.clr_i = 4'b0000;
        chk("ev3_edge", bus_a.edge_o, 4'b0001);
        chk("ev3_pend", bus_a.pending_o, 4'b0001);
        chk("ev3_ovf", bus_a.overflow_o, 4'b0000);
        tick();
        chk("ev3_pend_hold", bus_a.pending_o, 4'b0001);
        chk("ev3_ovf_hold", bus_a.overflow_o, 4'b0000);
        bus_a.clr_i = 4'b1111;
        tick();
        bus_a.clr_i = 4'b0000;

        // All channels toggle together in mode 11.
        bus_a.mode_i = 8'hFF;
        edge_or = '0;
        bus_a.in_i = 4'b0111; run_a(5);
        chk("all_noedge", edge_or, 4'b0000);
        chk("all_level", bus_a.level_o, 4'b0111);
        tick();
        chk("all_edge", bus_a.edge_o, 4'b1111);
        chk("all_dir", bus_a.dir_o, 4'b0111);
        chk("all_pend", bus_a.pending_o, 4'b1111);
        chk("all_any", bus_a.any_pending_o, 1'b1);
        tick();
        chk("all_edge_end", bus_a.edge_o, 4'b0000);

        // Reset during a pulse, then release with in_i away from reset level.
        bus_a.in_i = 4'b1000; run_a(6);
        chk("mid_edge", bus_a.edge_o, 4'b1111);
        rst_a = 1'b0;
        #1;
        chk("mid_rst_edge", bus_a.edge_o, 4'b0000);
        chk("mid_rst_dir", bus_a.dir_o, 4'b0000);
        chk("mid_rst_pend", bus_a.pending_o, 4'b0000);
        chk("mid_rst_ovf", bus_a.overflow_o, 4'b0000);
        chk("mid_rst_any", bus_a.any_pending_o, 1'b0);
        chk("mid_rst_level", bus_a.level_o, 4'b0000);
        tick();
        rst_a = 1'b1;
        edge_or = '0;
        run_a(5);
        chk("rel_noedge", edge_or, 4'b0000);
        tick();
        chk("rel_edge", bus_a.edge_o, 4'b1000);
        chk("rel_dir", bus_a.dir_o, 4'b1000);

        // Instance b: RESET_LEVEL=1 with inputs high through release.
        edge_or = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            edge_or = edge_or | bus_b.edge_o;
        end
        chk("b_rel_edge", edge_or, 4'b0000);
        chk("b_rel_pend", bus_b.pending_o, 4'b0000);
        chk("b_rel_level", bus_b.level_o, 4'b1111);
        bus_b.in_i = 4'b0000;
        tick(); tick(); tick(); tick();
        chk("b_filter_level", bus_b.level_o, 4'b1111);
        rst_b = 1'b0;
        #1;
        chk("b_rst_level", bus_b.level_o, 4'b1111);
        chk("b_rst_edge", bus_b.edge_o, 4'b0000);
        chk("b_rst_pend", bus_b.pending_o, 4'b0000);
        chk("b_rst_any", bus_b.any_pending_o, 1'b0);
        bus_b.in_i = 4'b1111;
        tick();
        rst_b = 1'b1;
        edge_or = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            edge_or = edge_or | bus_b.edge_o;
        end
        chk("b_after_edge", edge_or, 4'b0000);
        chk("b_after_level", bus_b.level_o, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/edge_detector_multi.md
EDGE_DETECTOR_MULTI -- requirements
Module: edge_detector_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent channels, 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, 0..4; 0 means no synchroniser.
REQ-003 SHALL have parameter FILTER_CYCLES, default 3: consecutive stable cycles required to accept a level change, 1..255.
REQ-004 SHALL have parameter RESET_LEVEL, default 1'b0: reset value of every synchroniser flop and accepted level.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_i, input, WIDTH bits: raw channel inputs, may be asynchronous to clk.
REQ-008 SHALL have port mode_i, input, 2*WIDTH bits: per-channel mode, bits [2i+1:2i]; 00 off, 01 rise, 10 fall, 11 both.
REQ-009 SHALL have port clr_i, input, WIDTH bits: per-channel clear of pending and overflow.
REQ-010 SHALL have port level_o, output, WIDTH bits: accepted (filtered) level per channel.
REQ-011 SHALL have port edge_o, output, WIDTH bits: one-cycle event pulse per channel.
REQ-012 SHALL have port dir_o, output, WIDTH bits: direction of the event; 1 rising, 0 falling; valid only while edge_o is high, else 0.
REQ-013 SHALL have port pending_o, output, WIDTH bits: sticky event flag per channel.
REQ-014 SHALL have port overflow_o, output, WIDTH bits: sticky flag, set when an event occurs while pending is already set.
REQ-015 SHALL have port any_pending_o, output, 1 bit: OR-reduction of pending_o.

Function
REQ-016 Each channel SHALL pass in_i through SYNC_STAGES flops to give the synced value s; with SYNC_STAGES=0, s SHALL equal in_i.
REQ-017 Each channel SHALL hold the accepted level acc and a filter counter cnt of width clog2(FILTER_CYCLES)+1.
REQ-018 When s equals acc, cnt SHALL be set to 0.
REQ-019 When s differs from acc and cnt equals FILTER_CYCLES-1, acc SHALL be set to s and cnt SHALL be set to 0; otherwise cnt SHALL increment.
REQ-020 Any return of s to acc before acceptance SHALL reset cnt to 0, so glitches shorter than FILTER_CYCLES synced cycles produce no change.
REQ-021 An acc transition SHALL be qualifying if it is 0->1 with mode bit 0 set, or 1->0 with mode bit 1 set.
REQ-022 mode_i SHALL be sampled in the cycle in which acc updates.
REQ-023 A qualifying transition SHALL register edge_o=1 and dir_o=new acc for exactly the following cycle.
REQ-024 Total latency from a clean in_i change to edge_o SHALL be SYNC_STAGES+FILTER_CYCLES+1 clk edges.
REQ-025 A non-qualifying transition, including any transition with mode 00, SHALL still update level_o, and SHALL NOT assert edge_o, pending_o or overflow_o.
REQ-026 pending_o SHALL be set in the same cycle edge_o asserts.
REQ-027 overflow_o SHALL be set in the cycle edge_o asserts if pending_o was already 1 on the preceding edge.
REQ-028 clr_i[i] SHALL clear pending_o[i] and overflow_o[i] on the next edge.
REQ-029 If clr_i[i] coincides with a new event on channel i, pending SHALL end at 1 and overflow SHALL end at 0 (set wins for pending, clear wins for overflow).
REQ-030 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported in the same cycle.
REQ-031 level_o SHALL equal acc directly; any_pending_o SHALL be combinational from pending state.

Reset
REQ-032 While rst_n=0, all synchroniser flops and acc SHALL equal RESET_LEVEL; cnt, edge_o, dir_o, pending_o and overflow_o SHALL be 0; any_pending_o SHALL be 0; the reset SHALL take effect immediately, without waiting for clk.
REQ-033 Deassertion of rst_n SHALL produce no edge_o, even if in_i differs from RESET_LEVEL, until the filter accepts the change.
REQ-034 Reset asserted mid-filter or mid-pulse SHALL abort the operation, with no residual pulse after release.

Verification
REQ-035 Scenario: defaults, mode=01, in_i[0] 0->1 held -> edge_o[0]=1 and dir_o[0]=1 for one cycle, 6 edges after the change; pending_o[0]=1; level_o[0]=1.
REQ-036 Scenario: defaults, in_i[1] high-pulse 2 synced cycles wide -> no edge_o, level_o[1] stays 0, cnt returns to 0.
REQ-037 Scenario: mode=10 on ch2, rise then fall -> only the fall pulses, dir_o[2]=0; with mode=00 -> level_o tracks, no pulse, no pending.
REQ-038 Scenario: two qualifying events on ch0 with no clear -> overflow_o[0]=1; clr_i[0] on the second event's pulse cycle -> pending_o[0]=1, overflow_o[0]=0.
REQ-039 Scenario: RESET_LEVEL=1, in_i all 1 through reset release -> no pulses; rst_n asserted mid-filter -> all outputs 0 immediately and level_o returns to 1.
REQ-040 Scenario: all WIDTH channels toggle together, mode 11 -> edge_o all-ones for one cycle, any_pending_o=1.
